led_array_s_axi_lite_if: RTL
============================

LED_ARRAY_S_AXI_LITE_IF -- requirements
Module: led_array_s_axi_lite_if

Interface
REQ-001 SHALL have parameter N_CH, default 3, number of LED channels, legal range 1..8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 7, AXI byte-address width, at least clog2(4*(4+2*N_CH)).
REQ-003 SHALL have ports aclk  in  1  sole clock; areset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have AXI4-Lite slave ports awaddr/araddr (ADDR_WIDTH), awvalid/awready, wdata (32), wstrb (4), wvalid/wready, bresp (2), bvalid/bready, arvalid/arready, rdata (32), rresp (2), rvalid/rready; awprot/arprot (3) are ignored.
REQ-005 SHALL have ports user_resetn  out  1  block soft reset, active-low; irq  out  1  level interrupt.
REQ-006 SHALL have ports mode/enable/hold  out  N_CH each  per-channel bits; duration  out  N_CH*32  channel k in bits [32k+31:32k].
REQ-007 SHALL have port led_sts  in  N_CH  LED state, synchronous to aclk.

Function
REQ-008 Register index SHALL be addr[ADDR_WIDTH-1:2]: 0 CTRL (bit0 user_resetn, RW), 1 STATUS (live led_sts, RO), 2 EVENT (sticky rising edges of led_sts, W1C), 3 IRQ_EN (RW, N_CH bits), 4+2k CH_CTRL k (bit0 mode, bit1 enable, bit2 hold, RW), 5+2k CH_DUR k (32-bit RW).
REQ-009 Unimplemented bits SHALL read 0; writes to STATUS SHALL be ignored with OKAY.
REQ-010 AW and W SHALL be accepted independently; each ready is high when its channel buffer is empty and no B response is pending.
REQ-011 The register write SHALL occur in the cycle after both AW and W are held, with bvalid asserted in that same cycle.
REQ-012 bvalid SHALL stay high until bready; no new AW or W SHALL be accepted while bvalid is high.
REQ-013 wstrb SHALL be honoured per byte lane; unstrobed bytes SHALL retain their value.
REQ-014 Index >= 4+2*N_CH SHALL return SLVERR (2'b10) on B/R, change no state, and read 0; all other accesses SHALL return OKAY.
REQ-015 arready SHALL pulse for one cycle when arvalid is high and rvalid is low.
REQ-016 rvalid and rdata SHALL be registered one cycle after the AR handshake and held stable until rready.
REQ-017 Read and write channels SHALL operate concurrently without interaction.
REQ-018 EVENT bit k SHALL set when led_sts[k] is 1 and its registered previous value is 0.
REQ-019 If an EVENT set and a W1C of the same bit occur in the same cycle, the set SHALL win.
REQ-020 irq SHALL be registered as OR(EVENT & IRQ_EN), one cycle after the EVENT update.
REQ-021 Outputs SHALL be driven directly from register bits, with zero added latency.

Reset
REQ-022 areset SHALL asynchronously clear all registers, the edge-detect history, and the AW/W buffers.
REQ-023 On reset, awready, wready, arready, bvalid, rvalid, irq, bresp, rresp and rdata SHALL be 0.
REQ-024 On reset, user_resetn SHALL be 0, keeping the user logic in reset until software sets CTRL bit0.
REQ-025 Reset asserted mid-transaction SHALL abort the transaction; no partial write SHALL survive.

Structure
REQ-026 A shared package SHALL hold the register index constants, CH_CTRL bit positions, and AXI response codes OKAY and SLVERR.
REQ-027 One sub-module, led_array_evt_capture, SHALL implement the edge detect, sticky EVENT with W1C, and irq for N_CH bits.

Verification
REQ-028 Write 0x0000_0003 to CH_CTRL 1 (addr 0x18), AW 3 cycles before W -> bresp OKAY; enable[1]=1 and mode[1]=1; read-back 0x3.
REQ-029 Write 0xAABBCCDD to CH_DUR 0 (0x14), then 0x11223344 with wstrb=0100 -> duration[31:0]=0xAA22CCDD.
REQ-030 Read addr 0x50 with N_CH=3 -> rresp=2'b10, rdata=0; a write there -> bresp=2'b10 and no register changes.
REQ-031 IRQ_EN=0x1, led_sts[0] 0->1 -> EVENT=0x1; irq=1 one cycle later; W1C 0x1 clears irq; W1C coincident with a new edge leaves the bit set.
REQ-032 Hold bready low 10 cycles -> bvalid stays high, awready/wready stay 0; rready low -> rdata stable.
REQ-033 Assert areset during a pending bvalid and held AW -> all valids 0; registers 0; a following full write completes normally.

Source files
------------

// File: rtl/led_array_pkg.sv
// Shared definitions for the LED array AXI4-Lite register block:
// register indices, CH_CTRL bit positions, AXI response codes and a
// byte-lane merge helper.
package led_array_pkg;

  localparam int unsigned REG_CTRL    = 0;
  localparam int unsigned REG_STATUS  = 1;
  localparam int unsigned REG_EVENT   = 2;
  localparam int unsigned REG_IRQ_EN  = 3;
  localparam int unsigned REG_CH_BASE = 4;

  localparam int unsigned CH_MODE_BIT   = 0;
  localparam int unsigned CH_ENABLE_BIT = 1;
  localparam int unsigned CH_HOLD_BIT   = 2;
  localparam int unsigned CH_CTRL_W     = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Replace only the strobed byte lanes of old with data.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/led_array_evt_capture.sv
// Rising-edge capture of led_sts into sticky EVENT bits with W1C, plus the
// registered level interrupt.
// Ports: clk/rst (async, active-high); led_sts in; irq_en in; clr in
// (W1C mask, one-cycle); evt_bits out (EVENT register); irq out.
module led_array_evt_capture
  import led_array_pkg::*;
#(
  parameter int unsigned N_CH = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] led_sts,
  input  logic [N_CH-1:0] irq_en,
  input  logic [N_CH-1:0] clr,
  output logic [N_CH-1:0] evt_bits,
  output logic            irq
);

  logic [N_CH-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= '0;
      evt_bits <= '0;
      irq      <= 1'b0;
    end else begin
      prev     <= led_sts;
      // Set term is OR-ed after the clear so a coincident edge wins.
      evt_bits <= (evt_bits & ~clr) | (led_sts & ~prev);
      irq      <= |(evt_bits & irq_en);
    end
  end

endmodule

// File: rtl/led_array_s_axi_lite_if.sv
// AXI4-Lite slave register block for an LED array controller.
// Ports: aclk/areset (async, active-high); AXI4-Lite slave AW/W/B/AR/R;
// user_resetn (soft reset, active-low); irq; per-channel mode/enable/hold;
// duration (32 bits per channel); led_sts (LED state input).
module led_array_s_axi_lite_if
  import led_array_pkg::*;
#(
  parameter int unsigned N_CH       = 3,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [2:0]           awprot,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [2:0]           arprot,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [31:0]          rdata,
  output logic [1:0]           rresp,
  output logic                 rvalid,
  input  logic                 rready,
  output logic                 user_resetn,
  output logic                 irq,
  output logic [N_CH-1:0]      mode,
  output logic [N_CH-1:0]      enable,
  output logic [N_CH-1:0]      hold,
  output logic [N_CH*32-1:0]   duration,
  input  logic [N_CH-1:0]      led_sts
);

  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam int unsigned N_REGS = REG_CH_BASE + 2 * N_CH;

  // Holds all ready outputs low while in reset and for the first cycle after.
  logic                 ready_en;
  logic                 aw_full;
  logic [IDX_W-1:0]     aw_idx;
  logic                 w_full;
  logic [31:0]          w_data;
  logic [3:0]           w_strb;

  logic                 ctrl_q;
  logic [N_CH-1:0]      irq_en_q;
  logic [CH_CTRL_W-1:0] ch_ctrl_q [N_CH];
  logic [31:0]          ch_dur_q  [N_CH];
  logic [N_CH-1:0]      evt_bits;
  logic [N_CH-1:0]      evt_clr;

  logic [31:0]          regs_view [N_REGS];
  logic [31:0]          wr_sel;
  logic [31:0]          rd_sel;
  logic [31:0]          wr_cur;
  logic [31:0]          wr_merged;
  logic [31:0]          rd_val;
  logic                 wr_fire;
  logic                 wr_ok;
  logic                 rd_ok;

  logic                 unused_bits;
  assign unused_bits = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

  assign awready = ready_en & ~aw_full & ~bvalid;
  assign wready  = ready_en & ~w_full & ~bvalid;
  assign arready = ready_en & arvalid & ~rvalid;

  assign wr_fire = aw_full & w_full & ~bvalid;
  assign wr_sel  = 32'(aw_idx);
  assign rd_sel  = 32'(araddr[ADDR_WIDTH-1:2]);
  assign wr_ok   = wr_sel < N_REGS;
  assign rd_ok   = rd_sel < N_REGS;

  always_comb begin
    for (int unsigned i = 0; i < N_REGS; i++) regs_view[i] = '0;
    regs_view[REG_CTRL]   = {31'b0, ctrl_q};
    regs_view[REG_STATUS] = 32'(led_sts);
    regs_view[REG_EVENT]  = 32'(evt_bits);
    regs_view[REG_IRQ_EN] = 32'(irq_en_q);
    for (int unsigned k = 0; k < N_CH; k++) begin
      regs_view[REG_CH_BASE + 2*k]     = 32'(ch_ctrl_q[k]);
      regs_view[REG_CH_BASE + 2*k + 1] = ch_dur_q[k];
    end
  end

  always_comb begin
    wr_cur = '0;
    rd_val = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (wr_sel == i) wr_cur = regs_view[i];
      if (rd_sel == i) rd_val = regs_view[i];
    end
    wr_merged = apply_wstrb(wr_cur, w_data, w_strb);
  end

  always_comb begin
    evt_clr = '0;
    if (wr_fire && wr_ok && wr_sel == REG_EVENT && w_strb[0]) evt_clr = w_data[N_CH-1:0];
  end

  // Write path: AW and W buffered independently, register update and
  // bvalid share the same edge.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ready_en <= 1'b0;
      aw_full  <= 1'b0;
      aw_idx   <= '0;
      w_full   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      ctrl_q   <= 1'b0;
      irq_en_q <= '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        ch_ctrl_q[k] <= '0;
        ch_dur_q[k]  <= '0;
      end
    end else begin
      ready_en <= 1'b1;
      if (awvalid && awready) begin
        aw_full <= 1'b1;
        aw_idx  <= awaddr[ADDR_WIDTH-1:2];
      end
      if (wvalid && wready) begin
        w_full <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end
      if (wr_fire) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) begin
          if (wr_sel == REG_CTRL)   ctrl_q   <= wr_merged[0];
          if (wr_sel == REG_IRQ_EN) irq_en_q <= wr_merged[N_CH-1:0];
          for (int unsigned k = 0; k < N_CH; k++) begin
            if (wr_sel == REG_CH_BASE + 2*k)     ch_ctrl_q[k] <= wr_merged[CH_CTRL_W-1:0];
            if (wr_sel == REG_CH_BASE + 2*k + 1) ch_dur_q[k]  <= wr_merged;
          end
        end
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (arvalid && arready) begin
      rvalid <= 1'b1;
      rdata  <= rd_ok ? rd_val : '0;
      rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

  led_array_evt_capture #(.N_CH(N_CH)) u_evt (
    .clk      (aclk),
    .rst      (areset),
    .led_sts  (led_sts),
    .irq_en   (irq_en_q),
    .clr      (evt_clr),
    .evt_bits (evt_bits),
    .irq      (irq)
  );

  assign user_resetn = ctrl_q;

  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      mode[k]             = ch_ctrl_q[k][CH_MODE_BIT];
      enable[k]           = ch_ctrl_q[k][CH_ENABLE_BIT];
      hold[k]             = ch_ctrl_q[k][CH_HOLD_BIT];
      duration[32*k +: 32] = ch_dur_q[k];
    end
  end

endmodule
